multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter ALU_CTRL_WIDTH, default 4, giving the alu_control width (minimum 4).
REQ-002 The block SHALL have parameter MEM_HANDSHAKE, default 1; 1 = memory states wait for mem_ready, 0 = mem_ready treated as constant 1.
REQ-003 The block SHALL have parameter SUPPORT_JUMP, default 1; 0 = opcode j treated as illegal.
REQ-004 The block SHALL have parameter COUNT_WIDTH, default 32, giving the retired-instruction counter width.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with the ports named clock and reset.
REQ-006 The block SHALL have these ports: clock in 1 system clock; reset in 1 synchronous active-high reset; opcode in 6 instruction[31:26]; funct in 6 instruction[5:0]; zero in 1 ALU zero flag; mem_ready in 1 memory access complete.
REQ-007 The block SHALL have these output ports: pc_write out 1; ir_write out 1; iord out 1 (1 = data address); mem_read out 1; mem_write out 1; reg_write out 1; reg_dst out 1 (1 = rd); mem_to_reg out 1; alu_src_a out 1 (1 = rs); alu_src_b out 2 (00 rt, 01 const 4, 10 signext imm, 11 imm<<2); pc_source out 2 (00 ALU, 01 ALUOut, 10 jump target).
REQ-008 The block SHALL have these status output ports: alu_control out ALU_CTRL_WIDTH; state out 4 current state code; illegal out 1 sticky trap flag; instr_count out COUNT_WIDTH retired instructions.

Function
REQ-009 State codes SHALL be: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, ADDI_EXEC 9, ADDI_WB 10, JUMP 11, TRAP 12; codes 13-15 SHALL go to TRAP on the next edge.
REQ-010 The state register SHALL update on the rising clock edge; all control outputs SHALL be combinational from state, plus mem_ready/zero where stated; any control not listed for a state SHALL be 0.
REQ-011 alu_control SHALL be zero-extended 4-bit codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-012 FETCH SHALL drive mem_read=1, alu_src_b=01, ADD, and ir_write=pc_write=mem_ready; it SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-013 DECODE SHALL drive alu_src_b=11, ADD and SHALL dispatch: 000000 -> EXECUTE (funct legal) else TRAP; 100011/101011 -> MEM_ADDR; 000100 -> BRANCH; 001000 -> ADDI_EXEC; 000010 -> JUMP if SUPPORT_JUMP else TRAP; others -> TRAP.
REQ-014 Legal R-type funct values SHALL be 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT.
REQ-015 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, ADD; the next state SHALL be MEM_READ for lw and MEM_WRITE for sw.
REQ-016 MEM_READ SHALL drive iord=1, mem_read=1 and hold until mem_ready=1, then go to MEM_WB; MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0 and then go to FETCH.
REQ-017 MEM_WRITE SHALL drive iord=1, mem_write=1 and hold until mem_ready=1, then go to FETCH.
REQ-018 EXECUTE SHALL drive alu_src_a=1, alu_src_b=00, with alu_control decoded from funct; ALU_WB SHALL drive reg_write=1, reg_dst=1 and then go to FETCH.
REQ-019 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, SUB, pc_source=01, pc_write=zero, and then go to FETCH.
REQ-020 ADDI_EXEC SHALL drive alu_src_a=1, alu_src_b=10, ADD; ADDI_WB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-021 JUMP SHALL drive pc_source=10, pc_write=1, and then go to FETCH.
REQ-022 TRAP SHALL assert no enables and SHALL be left only by reset; illegal SHALL be set on the edge entering TRAP and SHALL hold until reset.
REQ-023 instr_count SHALL increment by 1 on each edge from MEM_WB, MEM_WRITE (with mem_ready=1), ALU_WB, BRANCH, ADDI_WB or JUMP into FETCH, and SHALL wrap modulo 2^COUNT_WIDTH.
REQ-024 With mem_ready held at 1, latency in cycles SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-025 reset=1 at a clock edge SHALL set state=FETCH, illegal=0 and instr_count=0, overriding any in-progress access, wait or TRAP.
REQ-026 While reset=1, pc_write, ir_write, mem_read, mem_write and reg_write SHALL be forced to 0.
REQ-027 After reset deasserts, the first FETCH cycle SHALL start a fresh instruction.

Verification
REQ-028 Scenario: lw (100011) with mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 only in state 4; instr_count 0 -> 1.
REQ-029 Scenario: sw with mem_ready low for 3 cycles in MEM_WRITE -> mem_write held for 4 cycles; exactly one instr_count increment.
REQ-030 Scenario: beq with zero=0, then beq with zero=1 -> pc_write=0 in the first BRANCH and 1 in the second; both take 3 cycles.
REQ-031 Scenario: R-type funct 100111 -> alu_control=1100 in EXECUTE; funct 000001 -> TRAP, illegal=1, state held at 12 across 10 cycles.
REQ-032 Scenario: j with SUPPORT_JUMP=0 -> TRAP; reset asserted during a MEM_READ wait -> state=0, illegal=0, count=0 next edge, all enables 0 while reset=1.
REQ-033 Scenario: COUNT_WIDTH=4 with 17 addi instructions -> instr_count wraps to 1.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: sequences fetch/decode/execute/memory/writeback,
// traps on illegal encodings and counts retired instructions.
module multicycle_control #(
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int MEM_HANDSHAKE  = 1,
  parameter int SUPPORT_JUMP   = 1,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [5:0]                opcode,
  input  logic [5:0]                funct,
  input  logic                      zero,
  input  logic                      mem_ready,
  output logic                      pc_write,
  output logic                      ir_write,
  output logic                      iord,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic                      reg_write,
  output logic                      reg_dst,
  output logic                      mem_to_reg,
  output logic                      alu_src_a,
  output logic [1:0]                alu_src_b,
  output logic [1:0]                pc_source,
  output logic [ALU_CTRL_WIDTH-1:0] alu_control,
  output logic [3:0]                state,
  output logic                      illegal,
  output logic [COUNT_WIDTH-1:0]    instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_illegal;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_mem_ready;
  logic                   w_funct_legal;
  logic [3:0]             w_funct_alu;
  logic [3:0]             w_alu4;
  logic                   w_retire;

  assign w_mem_ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  always_comb begin
    w_funct_legal = 1'b1;
    w_funct_alu   = ALU_AND;
    case (funct)
      6'b100000: w_funct_alu = ALU_ADD;
      6'b100010: w_funct_alu = ALU_SUB;
      6'b100100: w_funct_alu = ALU_AND;
      6'b100101: w_funct_alu = ALU_OR;
      6'b100111: w_funct_alu = ALU_NOR;
      6'b101010: w_funct_alu = ALU_SLT;
      default:   w_funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next = S_TRAP;
    case (r_state)
      S_FETCH:     w_next = w_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      w_next = w_funct_legal ? S_EXECUTE : S_TRAP;
          OP_LW, OP_SW:  w_next = S_MEM_ADDR;
          OP_BEQ:        w_next = S_BRANCH;
          OP_ADDI:       w_next = S_ADDI_EXEC;
          OP_J:          w_next = (SUPPORT_JUMP != 0) ? S_JUMP : S_TRAP;
          default:       w_next = S_TRAP;
        endcase
      end
      // The instruction register still holds the opcode here, so it selects load vs store.
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      w_next = S_MEM_READ;
        else if (opcode == OP_SW) w_next = S_MEM_WRITE;
        else                      w_next = S_TRAP;
      end
      S_MEM_READ:  w_next = w_mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: w_next = w_mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   w_next = S_ALU_WB;
      S_ALU_WB:    w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      S_ADDI_WB:   w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      default:     w_next = S_TRAP;
    endcase
  end

  always_comb begin
    case (r_state)
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_ADDI_WB, S_JUMP: w_retire = 1'b1;
      S_MEM_WRITE: w_retire = w_mem_ready;
      default:     w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_retire)         r_count   <= r_count + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    w_alu4     = ALU_AND;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        w_alu4    = ALU_ADD;
        ir_write  = w_mem_ready;
        pc_write  = w_mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        w_alu4    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_alu4    = ALU_ADD;
      end
      S_MEM_READ: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        w_alu4    = w_funct_alu;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        w_alu4    = ALU_SUB;
        pc_source = 2'b01;
        pc_write  = zero;
      end
      S_ADDI_WB: reg_write = 1'b1;
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    // Reset gates every side-effecting enable regardless of the state being left.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign alu_control = ALU_CTRL_WIDTH'(w_alu4);
  assign state       = r_state;
  assign illegal     = r_illegal;
  assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vector table on the default build plus
// hand sequences on a no-jump, no-handshake, 4-bit-counter build.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
  //  alu_src_a} _ alu_src_b _ pc_source _ alu_control
  localparam logic [16:0] K_FETCH  = 17'b110100000_01_00_0010;
  localparam logic [16:0] K_FETCHW = 17'b000100000_01_00_0010;
  localparam logic [16:0] K_RSTF   = 17'b000000000_01_00_0010;
  localparam logic [16:0] K_DEC    = 17'b000000000_11_00_0010;
  localparam logic [16:0] K_MADDR  = 17'b000000001_10_00_0010;
  localparam logic [16:0] K_MREAD  = 17'b001100000_00_00_0000;
  localparam logic [16:0] K_RSTMR  = 17'b001000000_00_00_0000;
  localparam logic [16:0] K_MWB    = 17'b000001010_00_00_0000;
  localparam logic [16:0] K_MWR    = 17'b001010000_00_00_0000;
  localparam logic [16:0] K_EXNOR  = 17'b000000001_00_00_1100;
  localparam logic [16:0] K_ALUWB  = 17'b000001100_00_00_0000;
  localparam logic [16:0] K_BRN    = 17'b000000001_00_01_0110;
  localparam logic [16:0] K_BRT    = 17'b100000001_00_01_0110;
  localparam logic [16:0] K_AWB    = 17'b000001000_00_00_0000;
  localparam logic [16:0] K_JMP    = 17'b100000000_00_10_0000;
  localparam logic [16:0] K_ZERO   = 17'b0;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        ill;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    logic       ill;
    logic [3:0] cnt;
    logic       pw;
  } exp2_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // default build
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0, funct = '0;
  logic        zero = 1'b0, mem_ready = 1'b1;
  logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, pc_source;
  logic [3:0]  alu_control, state;
  logic        illegal;
  logic [31:0] instr_count;

  multicycle_control dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_control(alu_control), .state(state), .illegal(illegal),
    .instr_count(instr_count)
  );

  // no-jump / no-handshake / 4-bit counter build
  logic        rst2 = 1'b1;
  logic [5:0]  op2 = '0;
  logic        rdy2 = 1'b0;
  logic        pw2, irw2, iord2, mr2, mw2, rw2, rd2, m2r2, asa2;
  logic [1:0]  asb2, pcs2;
  logic [3:0]  alu2, st2;
  logic        ill2;
  logic [3:0]  cnt2;

  multicycle_control #(.MEM_HANDSHAKE(0), .SUPPORT_JUMP(0), .COUNT_WIDTH(4)) dut2 (
    .clock(clock), .reset(rst2), .opcode(op2), .funct(6'd0), .zero(1'b0),
    .mem_ready(rdy2), .pc_write(pw2), .ir_write(irw2), .iord(iord2),
    .mem_read(mr2), .mem_write(mw2), .reg_write(rw2), .reg_dst(rd2),
    .mem_to_reg(m2r2), .alu_src_a(asa2), .alu_src_b(asb2),
    .pc_source(pcs2), .alu_control(alu2), .state(st2), .illegal(ill2),
    .instr_count(cnt2)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  vec_t  sb[$];
  exp2_t sb2[$];
  vec_t  tbl[$];

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t v(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic rdy, input logic [3:0] st,
                             input logic [16:0] ctl, input logic ill, input int cnt);
    vec_t r;
    r.rst = rst; r.op = op; r.fn = fn; r.z = z; r.rdy = rdy;
    r.st = st; r.ctl = ctl; r.ill = ill; r.cnt = cnt;
    return r;
  endfunction

  task automatic apply(input vec_t x, input int idx);
    vec_t e;
    @(negedge clock);
    reset = x.rst; opcode = x.op; funct = x.fn; zero = x.z; mem_ready = x.rdy;
    sb.push_back(x);
    #1;
    e = sb.pop_front();
    cmp("state", idx, 32'(state), 32'(e.st));
    cmp("ctl", idx, 32'({pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
                         mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_control}), 32'(e.ctl));
    cmp("illegal", idx, 32'(illegal), 32'(e.ill));
    cmp("count", idx, instr_count, e.cnt);
  endtask

  task automatic step2(input logic [5:0] op, input logic [3:0] st, input logic ill,
                       input int cnt, input logic pw, input int idx);
    exp2_t x, e;
    @(negedge clock);
    rst2 = 1'b0; op2 = op; rdy2 = 1'b0;
    x.st = st; x.ill = ill; x.cnt = 4'(cnt); x.pw = pw;
    sb2.push_back(x);
    #1;
    e = sb2.pop_front();
    cmp("b2_state", idx, 32'(st2), 32'(e.st));
    cmp("b2_illegal", idx, 32'(ill2), 32'(e.ill));
    cmp("b2_count", idx, 32'(cnt2), 32'(e.cnt));
    cmp("b2_pc_write", idx, 32'(pw2), 32'(e.pw));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    // reset, lw, sw with stalled write, beq not-taken/taken, R-type NOR, addi, j
    tbl.push_back(v(1, OP_LW,   0, 0, 1, 0,  K_RSTF,  0, 0));
    tbl.push_back(v(0, OP_LW,   0, 0, 1, 0,  K_FETCH, 0, 0));
    tbl.push_back(v(0, OP_LW,   0, 0, 1, 1,  K_DEC,   0, 0));
    tbl.push_back(v(0, OP_LW,   0, 0, 1, 2,  K_MADDR, 0, 0));
    tbl.push_back(v(0, OP_LW,   0, 0, 1, 3,  K_MREAD, 0, 0));
    tbl.push_back(v(0, OP_LW,   0, 0, 1, 4,  K_MWB,   0, 0));
    tbl.push_back(v(0, OP_SW,   0, 0, 1, 0,  K_FETCH, 0, 1));
    tbl.push_back(v(0, OP_SW,   0, 0, 1, 1,  K_DEC,   0, 1));
    tbl.push_back(v(0, OP_SW,   0, 0, 1, 2,  K_MADDR, 0, 1));
    tbl.push_back(v(0, OP_SW,   0, 0, 0, 5,  K_MWR,   0, 1));
    tbl.push_back(v(0, OP_SW,   0, 0, 0, 5,  K_MWR,   0, 1));
    tbl.push_back(v(0, OP_SW,   0, 0, 0, 5,  K_MWR,   0, 1));
    tbl.push_back(v(0, OP_SW,   0, 0, 1, 5,  K_MWR,   0, 1));
    tbl.push_back(v(0, OP_BEQ,  0, 0, 1, 0,  K_FETCH, 0, 2));
    tbl.push_back(v(0, OP_BEQ,  0, 0, 1, 1,  K_DEC,   0, 2));
    tbl.push_back(v(0, OP_BEQ,  0, 0, 1, 8,  K_BRN,   0, 2));
    tbl.push_back(v(0, OP_BEQ,  0, 1, 1, 0,  K_FETCH, 0, 3));
    tbl.push_back(v(0, OP_BEQ,  0, 1, 1, 1,  K_DEC,   0, 3));
    tbl.push_back(v(0, OP_BEQ,  0, 1, 1, 8,  K_BRT,   0, 3));
    tbl.push_back(v(0, OP_R,    6'b100111, 0, 1, 0, K_FETCH, 0, 4));
    tbl.push_back(v(0, OP_R,    6'b100111, 0, 1, 1, K_DEC,   0, 4));
    tbl.push_back(v(0, OP_R,    6'b100111, 0, 1, 6, K_EXNOR, 0, 4));
    tbl.push_back(v(0, OP_R,    6'b100111, 0, 1, 7, K_ALUWB, 0, 4));
    tbl.push_back(v(0, OP_ADDI, 0, 0, 1, 0,  K_FETCH, 0, 5));
    tbl.push_back(v(0, OP_ADDI, 0, 0, 1, 1,  K_DEC,   0, 5));
    tbl.push_back(v(0, OP_ADDI, 0, 0, 1, 9,  K_MADDR, 0, 5));
    tbl.push_back(v(0, OP_ADDI, 0, 0, 1, 10, K_AWB,   0, 5));
    tbl.push_back(v(0, OP_J,    0, 0, 1, 0,  K_FETCH, 0, 6));
    tbl.push_back(v(0, OP_J,    0, 0, 1, 1,  K_DEC,   0, 6));
    tbl.push_back(v(0, OP_J,    0, 0, 1, 11, K_JMP,   0, 6));
    // fetch stall, then reset in the middle of a load wait
    tbl.push_back(v(0, OP_LW,   0, 0, 0, 0,  K_FETCHW, 0, 7));
    tbl.push_back(v(0, OP_LW,   0, 0, 1, 0,  K_FETCH,  0, 7));
    tbl.push_back(v(0, OP_LW,   0, 0, 1, 1,  K_DEC,    0, 7));
    tbl.push_back(v(0, OP_LW,   0, 0, 1, 2,  K_MADDR,  0, 7));
    tbl.push_back(v(0, OP_LW,   0, 0, 0, 3,  K_MREAD,  0, 7));
    tbl.push_back(v(1, OP_LW,   0, 0, 0, 3,  K_RSTMR,  0, 7));
    // illegal funct traps
    tbl.push_back(v(0, OP_R,    6'b000001, 0, 1, 0,  K_FETCH, 0, 0));
    tbl.push_back(v(0, OP_R,    6'b000001, 0, 1, 1,  K_DEC,   0, 0));
    tbl.push_back(v(0, OP_R,    6'b000001, 0, 1, 12, K_ZERO,  1, 0));

    repeat (2) @(negedge clock);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // TRAP is sticky across arbitrary inputs
    for (int i = 0; i < 10; i++)
      apply(v(0, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 12, K_ZERO, 1, 0), 100 + i);
    apply(v(1, OP_BEQ, 0, 1, 1, 12, K_ZERO, 1, 0), 110);
    // fresh instruction after reset leaves TRAP
    apply(v(0, OP_BEQ, 0, 1, 1, 0, K_FETCH, 0, 0), 111);
    apply(v(0, OP_BEQ, 0, 1, 1, 1, K_DEC,   0, 0), 112);
    apply(v(0, OP_BEQ, 0, 1, 1, 8, K_BRT,   0, 0), 113);
    apply(v(0, OP_BEQ, 0, 1, 1, 0, K_FETCH, 0, 1), 114);

    // second build: mem_ready ignored, 17 addi wrap the 4-bit counter, j traps
    @(negedge clock);
    rst2 = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 17; i++) begin
      step2(OP_ADDI, 0,  0, i % 16, 1, 200 + 4 * i);
      step2(OP_ADDI, 1,  0, i % 16, 0, 201 + 4 * i);
      step2(OP_ADDI, 9,  0, i % 16, 0, 202 + 4 * i);
      step2(OP_ADDI, 10, 0, i % 16, 0, 203 + 4 * i);
    end
    step2(OP_J, 0,  0, 1, 1, 300);
    step2(OP_J, 1,  0, 1, 0, 301);
    step2(OP_J, 12, 1, 1, 0, 302);
    step2(OP_J, 12, 1, 1, 0, 303);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
